// File: rtl/product_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : product_bcd_converter
//  Description : Takes the signed two's-complement product from the Booth
//                multiplier, splits it into sign and magnitude, and converts
//                the magnitude to packed BCD by sequential double-dabble
//                (shift-add-3). Start/ready handshake, one conversion at a
//                time. Results feed the seven-segment display driver.
//  Revision    : 1.0  initial release
// ============================================================================
module product_bcd_converter #(
    parameter int WORD_LENGTH = 8,
    parameter int DIGITS      = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [2*WORD_LENGTH-1:0]   Product,
    output logic                       busy,
    output logic                       ready,
    output logic                       Sign,
    output logic [4*DIGITS-1:0]        BCD
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int c_pw = 2 * WORD_LENGTH;          // product width
    localparam int c_bw = 4 * DIGITS;               // packed BCD width
    localparam int c_cw = $clog2(c_pw) + 1;         // shift counter width

    // Counter value during the final shift; the FSM leaves SHIFT on this edge.
    localparam logic [c_cw-1:0] c_last_shift = c_cw'(c_pw - 1);
    localparam logic [c_cw-1:0] c_cnt_one    = c_cw'(1);
    localparam logic [c_pw-1:0] c_one        = c_pw'(1);

    // State encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      w_next_state;

    logic [c_pw-1:0] r_product;      // product captured with start
    logic            r_sign;         // sign of the conversion in flight
    logic [c_pw-1:0] r_mag;          // magnitude shift register
    logic [c_bw-1:0] r_bcd;          // BCD working register (never shown)
    logic [c_cw-1:0] r_count;        // shifts completed so far

    logic [c_bw-1:0] r_bcd_out;      // output result registers: only
    logic            r_sign_out;     // updated on entry to DONE

    logic [c_pw-1:0] w_mag_abs;
    logic [c_bw-1:0] w_bcd_adj;
    logic [c_bw-1:0] w_bcd_shift;
    logic [c_pw-1:0] w_mag_shift;
    logic            w_last;

    // ------------------------------------------------------------------------
    // Datapath combinational helpers
    // ------------------------------------------------------------------------

    // Two's-complement negate for negative products. The most negative value
    // wraps onto itself, which read as unsigned is exactly its magnitude.
    assign w_mag_abs = r_product[c_pw-1] ? (~r_product + c_one) : r_product;

    // Add-3 correction per digit, applied before every shift so that a digit
    // of 5..9 carries correctly into the next digit after doubling.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                     (r_bcd[4*g +: 4] + 4'd3) :
                                      r_bcd[4*g +: 4];
    end

    // {bcd, mag} shifted left by one as a single concatenated register.
    assign w_bcd_shift = {w_bcd_adj[c_bw-2:0], r_mag[c_pw-1]};
    assign w_mag_shift = {r_mag[c_pw-2:0], 1'b0};
    assign w_last      = (r_count == c_last_shift);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic; start outside IDLE is simply not looked at
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_next_state = c_st_load;
                end
            end
            c_st_load: begin
                w_next_state = c_st_shift;
            end
            c_st_shift: begin
                if (w_last) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM outputs decoded from the current state
    // ------------------------------------------------------------------------
    always_comb begin
        busy  = 1'b0;
        ready = 1'b0;
        case (r_state)
            c_st_load:  busy  = 1'b1;
            c_st_shift: busy  = 1'b1;
            c_st_done:  ready = 1'b1;
            default: begin
                busy  = 1'b0;
                ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers: capture, load, shift and publish the result
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_product  <= '0;
            r_sign     <= 1'b0;
            r_mag      <= '0;
            r_bcd      <= '0;
            r_count    <= '0;
            r_bcd_out  <= '0;
            r_sign_out <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_product <= Product;
                    end
                end
                c_st_load: begin
                    r_sign  <= r_product[c_pw-1];
                    r_mag   <= w_mag_abs;
                    r_bcd   <= '0;
                    r_count <= '0;
                end
                c_st_shift: begin
                    r_bcd   <= w_bcd_shift;
                    r_mag   <= w_mag_shift;
                    r_count <= r_count + c_cnt_one;
                    // The final shifted value goes straight to the outputs
                    // on the same edge that enters DONE.
                    if (w_last) begin
                        r_bcd_out  <= w_bcd_shift;
                        r_sign_out <= r_sign;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign BCD  = r_bcd_out;
    assign Sign = r_sign_out;

endmodule
`default_nettype wire

// File: tb/tb_product_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_product_bcd_converter
//  Description : Scoreboard bench for product_bcd_converter. The driver pushes
//                hand-computed expected results; a monitor pops and compares
//                on every ready pulse, also checking latency and busy length.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_product_bcd_converter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] product = 16'h0000;
    logic        busy;
    logic        ready;
    logic        sign;
    logic [19:0] bcd;

    typedef struct {
        logic        sign;
        logic [19:0] bcd;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    product_bcd_converter #(
        .WORD_LENGTH (8),
        .DIGITS      (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .Product (product),
        .busy    (busy),
        .ready   (ready),
        .Sign    (sign),
        .BCD     (bcd)
    );

    always #5 clk = ~clk;

    // Edge counter: value seen at a negedge is the index of the last posedge
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
        end
    endtask

    // Issue one conversion; expected ready is 17 edges after the sampling edge
    task automatic issue(input logic [15:0] p, input logic [19:0] ebcd, input logic esign);
        exp_t e;
        wait_idle();
        product = p;
        start   = 1'b1;
        e.sign  = esign;
        e.bcd   = ebcd;
        e.due   = cyc + 1 + 17;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    initial begin
        fork
            // Monitor: compare on every ready pulse
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!reset) begin
                        busy_cnt = 0;
                    end else begin
                        if (busy) busy_cnt++;
                        if (ready) begin
                            if (sb.size() == 0) begin
                                tests++;
                                fails++;
                                $display("FAIL unexpected_ready: ready=1 bcd=%h, expected no pulse", bcd);
                            end else begin
                                e = sb.pop_front();
                                check("bcd", {12'h000, bcd}, {12'h000, e.bcd});
                                check("sign", {31'd0, sign}, {31'd0, e.sign});
                                check("latency", cyc, e.due);
                                check("busy_cycles", busy_cnt, 17);
                            end
                            busy_cnt = 0;
                        end
                    end
                end
            end
            // Driver
            begin
                repeat (3) @(negedge clk);
                check("rst_busy",  {31'd0, busy},  0);
                check("rst_ready", {31'd0, ready}, 0);
                check("rst_sign",  {31'd0, sign},  0);
                check("rst_bcd",   {12'h000, bcd}, 0);
                reset = 1'b1;
                @(negedge clk);

                issue(16'd91,   20'h00091, 1'b0);
                issue(16'hFFA5, 20'h00091, 1'b1);
                issue(16'h8000, 20'h32768, 1'b1);
                issue(16'h7FFF, 20'h32767, 1'b0);
                drain();
                // Outputs hold between conversions
                repeat (3) @(negedge clk);
                check("hold_bcd",  {12'h000, bcd}, 32'h32767);
                check("hold_sign", {31'd0, sign},  0);

                issue(16'd0, 20'h00000, 1'b0);

                // Start while busy is ignored; Product change has no effect
                issue(16'd91, 20'h00091, 1'b0);
                repeat (5) @(negedge clk);
                product = 16'd5;
                start   = 1'b1;
                @(negedge clk);
                start   = 1'b0;
                issue(16'd5, 20'h00005, 1'b0);
                drain();

                // Reset mid-conversion aborts without a ready pulse
                issue(16'hFFA5, 20'h00091, 1'b1);
                repeat (6) @(negedge clk);
                reset = 1'b0;
                sb.delete();
                @(negedge clk);
                check("abort_busy",  {31'd0, busy},  0);
                check("abort_ready", {31'd0, ready}, 0);
                check("abort_sign",  {31'd0, sign},  0);
                check("abort_bcd",   {12'h000, bcd}, 0);
                reset = 1'b1;
                repeat (20) @(negedge clk);
                issue(16'd1234, 20'h01234, 1'b0);
                drain();
                check("queue_empty", sb.size(), 0);
            end
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
